// File: rtl/image_feeder_if.sv
// Frame-memory read port and pixel stream of the image feeder.
// The master side is the feeder itself; the slave side is the memory plus
// the line-buffer controller pixel input.
interface image_feeder_if #(
  parameter int ADDR_W = 18
);
  logic              o_mem_rd;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [7:0]        i_mem_data;
  logic [7:0]        o_pixel_data;
  logic              o_pixel_data_valid;

  modport master (
    output o_mem_rd,
    output o_mem_addr,
    input  i_mem_data,
    output o_pixel_data,
    output o_pixel_data_valid
  );

  modport slave (
    input  o_mem_rd,
    input  o_mem_addr,
    output i_mem_data,
    input  o_pixel_data,
    input  o_pixel_data_valid
  );
endinterface

// File: rtl/image_feeder.sv
// Raster-order pixel source for the line-buffer front end.
// Reads one frame from a synchronous memory and streams it out, releasing
// lines against a credit counter that is primed at frame start and topped up
// by one credit per line-consumed interrupt from the line-buffer controller.
module image_feeder #(
  parameter int IMG_WIDTH   = 480,
  parameter int IMG_HEIGHT  = 480,
  parameter int PRIME_LINES = 6,
  parameter int MAX_CREDITS = 7,
  parameter int ADDR_W      = 18
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  output logic          o_busy,
  input  logic          i_intr,
  output logic          o_frame_done,
  output logic          o_credit_err,
  image_feeder_if.master bus
);

  localparam int COL_W  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int LINE_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMG_WIDTH - 1);
  localparam logic [LINE_W-1:0] LINE_LAST  = LINE_W'(IMG_HEIGHT - 1);
  localparam logic [2:0]        CRED_PRIME = 3'(PRIME_LINES);
  localparam logic [2:0]        CRED_MAX   = 3'(MAX_CREDITS);

  typedef enum logic [1:0] {
    IDLE,
    LINE,
    WAIT_CREDIT,
    FLUSH
  } state_t;

  state_t            state;
  logic [2:0]        credits;
  logic [COL_W-1:0]  col;
  logic [LINE_W-1:0] line;
  logic              vld_p0;

  logic              line_start;
  logic              intr_ok;
  logic              credit_sat;
  logic [2:0]        credits_nxt;

  // Saturating credit update; an interrupt that coincides with a line-start
  // consumption cancels it, so the count is left as is.
  function automatic logic [2:0] credit_update(input logic [2:0] c,
                                               input logic       inc,
                                               input logic       dec);
    logic [2:0] r;
    r = c;
    if (inc && !dec) begin
      if (c != CRED_MAX) r = c + 3'd1;
    end else if (dec && !inc) begin
      r = c - 3'd1;
    end
    return r;
  endfunction

  // Credit bookkeeping for the current cycle.
  always_comb begin
    line_start  = (state == LINE) && (col == '0);
    intr_ok     = i_intr && (state != IDLE);
    credit_sat  = intr_ok && !line_start && (credits == CRED_MAX);
    credits_nxt = credit_update(credits, intr_ok, line_start);
  end

  // Control FSM: read sequencing, credit counter, busy/done/error flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= IDLE;
      credits        <= '0;
      col            <= '0;
      line           <= '0;
      bus.o_mem_rd   <= 1'b0;
      bus.o_mem_addr <= '0;
      o_busy         <= 1'b0;
      o_frame_done   <= 1'b0;
      o_credit_err   <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (state != IDLE) credits <= credits_nxt;
      if (credit_sat) o_credit_err <= 1'b1;
      case (state)
        IDLE: begin
          if (i_start) begin
            credits        <= CRED_PRIME;
            bus.o_mem_addr <= '0;
            col            <= '0;
            line           <= '0;
            o_credit_err   <= 1'b0;
            o_busy         <= 1'b1;
            bus.o_mem_rd   <= 1'b1;
            state          <= LINE;
          end
        end
        LINE: begin
          bus.o_mem_addr <= bus.o_mem_addr + ADDR_W'(1);
          if (col != COL_LAST) begin
            col <= col + COL_W'(1);
          end else begin
            col <= '0;
            if (line == LINE_LAST) begin
              bus.o_mem_rd <= 1'b0;
              state        <= FLUSH;
            end else begin
              line <= line + LINE_W'(1);
              if (credits_nxt == '0) begin
                bus.o_mem_rd <= 1'b0;
                state        <= WAIT_CREDIT;
              end
            end
          end
        end
        WAIT_CREDIT: begin
          if (credits_nxt != '0) begin
            bus.o_mem_rd <= 1'b1;
            state        <= LINE;
          end
        end
        FLUSH: begin
          // Last pixel is on the output and nothing is left behind it.
          if (!vld_p0 && bus.o_pixel_data_valid) begin
            o_frame_done <= 1'b1;
            o_busy       <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-return pipeline: p0 marks memory data arriving, p1 is the output.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p0                 <= 1'b0;
      bus.o_pixel_data_valid <= 1'b0;
      bus.o_pixel_data       <= '0;
    end else begin
      vld_p0                 <= bus.o_mem_rd;
      bus.o_pixel_data_valid <= vld_p0;
      if (vld_p0) bus.o_pixel_data <= bus.i_mem_data;
    end
  end

endmodule

// File: tb/tb_image_feeder.sv
// Scoreboard bench for image_feeder on a small 8x10 frame.
module tb_image_feeder;

  localparam int W      = 8;
  localparam int H      = 10;
  localparam int ADDR_W = 18;
  localparam int NPIX   = W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic intr = 1'b0;
  logic busy, frame_done, credit_err;

  int cyc = 0;
  int nchk = 0;
  int nerr = 0;
  int pix_cnt = 0;
  int mark = 0;
  int first_cyc = -1;
  int last_cyc = -1;
  int done_cnt = 0;
  int done_cyc = -1;
  int t0;

  logic [7:0]        exp_pix[$];
  logic [ADDR_W-1:0] exp_addr[$];

  image_feeder_if #(.ADDR_W(ADDR_W)) bus ();

  image_feeder #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .PRIME_LINES(6), .MAX_CREDITS(7), .ADDR_W(ADDR_W)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .o_busy(busy),
    .i_intr(intr), .o_frame_done(frame_done), .o_credit_err(credit_err),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pix_of(input int a);
    return 8'(a * 37 + 11);
  endfunction

  // Synchronous frame memory model, one cycle read latency.
  always @(posedge clk) if (bus.o_mem_rd) bus.i_mem_data <= pix_of(int'(bus.o_mem_addr));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    if (obs !== expv) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Output monitor: addresses, pixels and frame_done.
  always @(negedge clk) begin
    if (bus.o_mem_rd) begin
      if (exp_addr.size() == 0) check("unexp_rd", 1, 0);
      else check("addr", 32'(bus.o_mem_addr), 32'(exp_addr.pop_front()));
    end
    if (bus.o_pixel_data_valid) begin
      if (pix_cnt == mark) first_cyc = cyc;
      last_cyc = cyc;
      pix_cnt++;
      if (exp_pix.size() == 0) check("unexp_pix", 1, 0);
      else check("pixel", 32'(bus.o_pixel_data), 32'(exp_pix.pop_front()));
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int i = 0; i < NPIX; i++) begin
      exp_addr.push_back(ADDR_W'(i));
      exp_pix.push_back(pix_of(i));
    end
  endtask

  task automatic start_frame();
    step();
    mark  = pix_cnt;
    start = 1'b1;
    t0    = cyc;
    push_frame();
    step();
    start = 1'b0;
  endtask

  task automatic intr_at(input int k);
    while (cyc < k) step();
    intr = 1'b1;
    step();
    intr = 1'b0;
  endtask

  task automatic wait_pix(input int n, input int budget);
    int b;
    b = budget;
    while (pix_cnt < n && b > 0) begin
      step();
      b--;
    end
    if (pix_cnt < n) check("timeout_pix", 0, 1);
  endtask

  task automatic wait_done(input int n, input int budget);
    int b;
    b = budget;
    while (done_cnt < n && b > 0) begin
      step();
      b--;
    end
    if (done_cnt < n) check("timeout_done", 0, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_rd"}, 32'(bus.o_mem_rd), 0);
    check({tag, "_addr"}, 32'(bus.o_mem_addr), 0);
    check({tag, "_pix"}, 32'(bus.o_pixel_data), 0);
    check({tag, "_vld"}, 32'(bus.o_pixel_data_valid), 0);
    check({tag, "_done"}, 32'(frame_done), 0);
    check({tag, "_cerr"}, 32'(credit_err), 0);
  endtask

  initial begin
    int c;
    int d0;
    int p0;
    bit started_b;

    // Reset state
    repeat (3) step();
    check_outputs_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) step();
    check("idle_pix", 32'(pix_cnt), 0);
    check("idle_busy", 32'(busy), 0);

    // Priming: six lines then stall
    d0 = done_cnt;
    start_frame();
    wait_pix(mark + 48, 200);
    repeat (20) step();
    check("prime_cnt", 32'(pix_cnt - mark), 48);
    check("prime_first", 32'(first_cyc), 32'(t0 + 3));
    check("prime_last", 32'(last_cyc), 32'(t0 + 50));
    check("prime_busy", 32'(busy), 1);

    // Credit release: one line per interrupt
    for (int b = 0; b < 4; b++) begin
      check("stall_rd", 32'(bus.o_mem_rd), 0);
      intr_at(cyc + 1);
      c = cyc - 1;
      @(negedge clk);
      check("burst_rd", 32'(bus.o_mem_rd), 1);
      check("burst_addr", 32'(bus.o_mem_addr), 32'(48 + 8 * b));
      @(negedge clk);
      check("burst_novld", 32'(bus.o_pixel_data_valid), 0);
      @(negedge clk);
      check("burst_vld", 32'(cyc - c), 3);
      check("burst_vld_hi", 32'(bus.o_pixel_data_valid), 1);
      repeat (17) step();
    end
    wait_done(d0 + 1, 50);
    repeat (3) step();
    check("rel_cnt", 32'(pix_cnt - mark), 80);
    check("rel_done_cnt", 32'(done_cnt - d0), 1);
    check("rel_done_cyc", 32'(done_cyc), 32'(last_cyc + 1));
    check("rel_busy", 32'(busy), 0);
    check("rel_q", 32'(exp_pix.size()), 0);

    // Interrupt coincides with line-6 first read while credits = 1
    d0 = done_cnt;
    start_frame();
    intr_at(t0 + 20);
    intr_at(t0 + 49);
    @(negedge clk);
    check("sim_credits", 32'(dut.credits), 1);
    wait_pix(mark + 64, 100);
    repeat (10) step();
    check("sim_cnt", 32'(pix_cnt - mark), 64);
    check("sim_first", 32'(first_cyc), 32'(t0 + 3));
    check("sim_last", 32'(last_cyc), 32'(t0 + 66));
    intr_at(cyc + 2);
    repeat (20) step();
    intr_at(cyc + 2);
    wait_done(d0 + 1, 60);
    check("sim_total", 32'(pix_cnt - mark), 80);

    // Credit overflow
    d0 = done_cnt;
    start_frame();
    intr = 1'b1;
    repeat (4) step();
    intr = 1'b0;
    @(negedge clk);
    check("ovf_cerr", 32'(credit_err), 1);
    check("ovf_credits", 32'(dut.credits), 7);
    wait_pix(mark + 64, 100);
    repeat (10) step();
    check("ovf_cnt", 32'(pix_cnt - mark), 64);
    intr_at(cyc + 2);
    repeat (20) step();
    intr_at(cyc + 2);
    wait_done(d0 + 1, 60);
    repeat (2) step();
    check("ovf_sticky", 32'(credit_err), 1);

    // Back-to-back frames, interrupt every 8th cycle, stray start mid-frame
    d0 = done_cnt;
    p0 = pix_cnt;
    started_b = 1'b0;
    for (int k = 0; k < 400; k++) begin
      step();
      intr  = (k % 8 == 0);
      start = 1'b0;
      if (k == 0) begin
        start = 1'b1;
        push_frame();
      end
      if (k == 2) check("b2b_cerr_clr", 32'(credit_err), 0);
      if (k == 30) begin
        check("b2b_busy", 32'(busy), 1);
        start = 1'b1;
      end
      if (done_cnt == d0 + 1 && !started_b) begin
        start = 1'b1;
        started_b = 1'b1;
        push_frame();
      end
      if (done_cnt == d0 + 2) break;
    end
    intr  = 1'b0;
    start = 1'b0;
    if (done_cnt < d0 + 2) check("timeout_b2b", 0, 1);
    repeat (3) step();
    check("b2b_done", 32'(done_cnt - d0), 2);
    check("b2b_cnt", 32'(pix_cnt - p0), 160);
    check("b2b_q", 32'(exp_pix.size()), 0);

    // Asynchronous reset mid-line
    d0 = done_cnt;
    start_frame();
    repeat (12) step();
    #1;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("arst");
    exp_pix.delete();
    exp_addr.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    p0 = pix_cnt;
    repeat (20) step();
    check("arst_nopix", 32'(pix_cnt - p0), 0);
    check("arst_nodone", 32'(done_cnt - d0), 0);
    check("arst_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

// File: doc/image_feeder.md
# image_feeder

Pixel source for the corner-detection line-buffer front end. It reads an 8-bit grayscale frame from a synchronous frame memory in raster order and drives it as a pixel stream into the 7-line buffer controller. Line-level flow control comes from that controller's per-line interrupt: six lines are primed, then one further line is released per interrupt, so the line buffers never overrun. It sits between the frame-memory port and the line-buffer controller's pixel input.

## Interface
- IMG_WIDTH, 480: pixels per line.
- IMG_HEIGHT, 480: lines per frame.
- PRIME_LINES, 6: line credits granted at frame start.
- MAX_CREDITS, 7: credit ceiling, equal to the number of line buffers.
- ADDR_W, 18: frame-memory address width; must satisfy 2^ADDR_W ≥ IMG_WIDTH*IMG_HEIGHT.
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle pulse that starts a frame; ignored while o_busy=1.
- o_busy  out  1  high from the cycle after an accepted i_start until the cycle o_frame_done pulses.
- o_mem_rd  out  1  read strobe to the frame memory.
- o_mem_addr  out  ADDR_W  read address; linear, row*IMG_WIDTH+col.
- i_mem_data  in  8  read data, valid exactly one cycle after o_mem_rd.
- o_pixel_data  out  8  pixel to the line-buffer controller.
- o_pixel_data_valid  out  1  pixel strobe.
- i_intr  in  1  one-cycle pulse from the line-buffer controller, one per line consumed.
- o_frame_done  out  1  one-cycle pulse after the last pixel of the frame.
- o_credit_err  out  1  sticky; set when i_intr arrives with credits at MAX_CREDITS; cleared by i_start.

## Operation
- States:
  - IDLE: waits for i_start.
  - LINE: issues one read per cycle for IMG_WIDTH cycles.
  - WAIT_CREDIT: no reads while credits = 0.
  - FLUSH: drains the 2-stage read pipeline.
- Accepted i_start: credits ← PRIME_LINES, address ← 0, line ← 0, o_credit_err ← 0. Next state is LINE.
- LINE:
  - o_mem_rd=1 every cycle; address increments by 1 each cycle.
  - A column counter runs 0..IMG_WIDTH-1.
  - Credits decrement by 1 on the first read of each line.
- At column IMG_WIDTH-1:
  - If line = IMG_HEIGHT-1 → FLUSH.
  - Else if credits (after any same-cycle i_intr) > 0 → LINE with no gap cycle.
  - Else → WAIT_CREDIT.
- WAIT_CREDIT: moves to LINE in the cycle after credits become nonzero.
- i_intr is counted in every state except IDLE:
  - credits +1, saturating at MAX_CREDITS; a saturating attempt sets o_credit_err.
  - i_intr in the same cycle as a line-start decrement leaves credits unchanged.
- FLUSH: after the last output pixel, o_frame_done pulses for one cycle, o_busy drops, and the state returns to IDLE. i_intr pulses arriving in IDLE are ignored.
- Credit counter is 3 bits. Line counter and column counter are sized with $clog2.

## Timing
- Reset (async assert, sync release): state IDLE; every output 0, including o_mem_addr, o_pixel_data and o_credit_err; credits 0; pipeline valids cleared.
- Reset mid-frame aborts immediately. No o_frame_done is produced, and no further pixels are emitted after release.
- Read latency: o_mem_rd at cycle t; i_mem_data is valid at t+1 and registered; o_pixel_data and o_pixel_data_valid are asserted at t+2.
- Valid runs are gap-free across line boundaries when credit is available.
- o_frame_done is asserted in the cycle after the final o_pixel_data_valid.
- First pixel: o_pixel_data_valid rises 3 cycles after the i_start cycle (start at t0, first read at t0+1, output at t0+3).
- Each frame delivers exactly IMG_WIDTH*IMG_HEIGHT valid pixels.

## Test plan
- Reset: assert i_rst_n=0 mid-line, asynchronously → all outputs 0 in the same cycle. After release, idle with no pixels until i_start.
- Priming (IMG_WIDTH=8, IMG_HEIGHT=10, no i_intr), i_start → exactly 48 contiguous valid pixels, values mem[0..47]. The block then sits in WAIT_CREDIT with o_busy=1.
- Credit release: from the stalled priming state, pulse i_intr four times, spaced 20 cycles apart → four more 8-pixel bursts. Each burst's first read occurs 1 cycle after its i_intr, and its first valid 3 cycles after that i_intr. After the 10th line, o_frame_done pulses once, the cycle after pixel 79 (value mem[79]).
- Simultaneous events: i_intr coincides with the first read of line 6 while credits=1 → credits stay 1 and line 7 follows with no gap.
- Overflow: hold credits at 7 and pulse i_intr → o_credit_err=1, credits stay 7. The next i_start clears o_credit_err.
- Back-to-back frames with i_intr tied high every 8th cycle → two frames of 80 pixels each, all addresses in order. i_start during frame 1 is ignored.
